// File: rtl/add_pipe.sv
// add_pipe: pipelined multi-lane signed adder with valid/ready flow control,
// per-lane running accumulators and optional saturation on signed overflow.
// Stage 1 captures the computed result on acceptance; later stages are pure
// delay registers, each with its own valid bit, joined by a combinational
// ready chain so that bubbles anywhere in the pipe are collapsed.
module add_pipe #(
   parameter int WIDTH    = 32,
   parameter int LANES    = 1,
   parameter int STAGES   = 1,
   parameter int SATURATE = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             mode,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] c,
   output logic [LANES-1:0]       ovf
);

   typedef enum logic [1:0] {
      MODE_ADD  = 2'b00,
      MODE_ACC  = 2'b01,
      MODE_LOAD = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   mode_e                  w_mode;
   logic                   w_accept;
   logic                   w_acc_write;
   logic [LANES*WIDTH-1:0] w_res;
   logic [LANES-1:0]       w_res_ovf;

   // Accumulators, one per lane.
   logic [WIDTH-1:0]       r_acc [LANES];

   // Pipeline stage registers; index 0 is stage 1, index STAGES-1 drives the outputs.
   logic [STAGES-1:0]      r_valid;
   logic [LANES*WIDTH-1:0] r_data [STAGES];
   logic [LANES-1:0]       r_ovf  [STAGES];

   // What each stage would load when it is free: stage 1 takes the new beat,
   // every later stage takes its predecessor.
   logic [STAGES-1:0]      w_free;
   logic [STAGES-1:0]      w_src_valid;
   logic [LANES*WIDTH-1:0] w_src_data [STAGES];
   logic [LANES-1:0]       w_src_ovf  [STAGES];

   assign w_mode      = mode_e'(mode);
   assign in_ready    = w_free[0];
   assign w_accept    = in_valid && w_free[0];
   // Reserved mode 11 falls into the "no accumulator write" group with ADD.
   assign w_acc_write = w_accept && ((w_mode == MODE_ACC) || (w_mode == MODE_LOAD));

   assign out_valid = r_valid[STAGES-1];
   assign c         = r_data[STAGES-1];
   assign ovf       = r_ovf[STAGES-1];

   // Ready chain: a stage is free when it is empty or everything downstream moves.
   always_comb begin : p_ready_chain
      logic w_chain;
      // NOTE: every combinational output gets a value on every path (default
      // first or full loop coverage), otherwise synthesis infers a latch.
      w_chain = out_ready;
      w_free  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_chain   = w_chain || !r_valid[k];
         w_free[k] = w_chain;
      end
   end

   // Per-lane arithmetic: WIDTH+1-bit sum, signed overflow detect, wrap or clamp.
   always_comb begin : p_lane_math
      logic [WIDTH-1:0] w_op_a;
      logic [WIDTH-1:0] w_op_b;
      logic [WIDTH:0]   w_sum;
      logic [WIDTH-1:0] w_lane_res;
      logic             w_lane_ovf;
      w_res     = '0;
      w_res_ovf = '0;
      for (int i = 0; i < LANES; i++) begin
         w_op_a = a[i*WIDTH +: WIDTH];
         w_op_b = (w_mode == MODE_ACC) ? r_acc[i] : b[i*WIDTH +: WIDTH];
         w_sum  = {w_op_a[WIDTH-1], w_op_a} + {w_op_b[WIDTH-1], w_op_b};
         // With sign-extended operands, the two top sum bits disagree exactly
         // when both operands share a sign that the WIDTH-bit result lost.
         w_lane_ovf = w_sum[WIDTH] != w_sum[WIDTH-1];
         if (w_mode == MODE_LOAD) begin
            w_lane_res = w_op_a;
            w_lane_ovf = 1'b0;
         end else if (w_lane_ovf && (SATURATE != 0)) begin
            // Operand sign tells the direction of the overflow.
            w_lane_res = w_op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            w_lane_res = w_sum[WIDTH-1:0];
         end
         w_res[i*WIDTH +: WIDTH] = w_lane_res;
         w_res_ovf[i]            = w_lane_ovf;
      end
   end

   // Source selection for each stage's load path.
   always_comb begin : p_stage_src
      w_src_valid    = '0;
      w_src_valid[0] = w_accept;
      w_src_data[0]  = w_res;
      w_src_ovf[0]   = w_res_ovf;
      for (int k = 1; k < STAGES; k++) begin
         w_src_valid[k] = r_valid[k-1];
         w_src_data[k]  = r_data[k-1];
         w_src_ovf[k]   = r_ovf[k-1];
      end
   end

   // Accumulator update on accepted ACC/LOAD beats, so the next beat chains on it.
   always_ff @(posedge clk or posedge rst) begin : p_acc
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            r_acc[i] <= '0;
         end
      end else if (w_acc_write) begin
         for (int i = 0; i < LANES; i++) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            r_acc[i] <= w_res[i*WIDTH +: WIDTH];
         end
      end
   end

   // Stage registers: a free stage loads its source; data only moves with a valid beat.
   always_ff @(posedge clk or posedge rst) begin : p_stages
      if (rst) begin
         // NOTE: the stage data arrays are reset explicitly because the output
         // bus must read zero after reset; this keeps them as flops, not RAM.
         r_valid <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
            r_ovf[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_free[k]) begin
               r_valid[k] <= w_src_valid[k];
               if (w_src_valid[k]) begin
                  r_data[k] <= w_src_data[k];
                  r_ovf[k]  <= w_src_ovf[k];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed checks of add_pipe in three configurations
//   ua: WIDTH=32 LANES=1 STAGES=1 wrap
//   ub: WIDTH=8  LANES=2 STAGES=1 saturate
//   uc: WIDTH=32 LANES=1 STAGES=3 wrap (accumulate, backpressure, reset, mode 11)
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
module tb_add_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance ua
   logic        ua_rst, ua_in_valid, ua_in_ready, ua_out_valid, ua_out_ready;
   logic [1:0]  ua_mode;
   logic [31:0] ua_a, ua_b, ua_c;
   logic [0:0]  ua_ovf;

   // Instance ub
   logic        ub_rst, ub_in_valid, ub_in_ready, ub_out_valid, ub_out_ready;
   logic [1:0]  ub_mode;
   logic [15:0] ub_a, ub_b, ub_c;
   logic [1:0]  ub_ovf;

   // Instance uc
   logic        uc_rst, uc_in_valid, uc_in_ready, uc_out_valid, uc_out_ready;
   logic [1:0]  uc_mode;
   logic [31:0] uc_a, uc_b, uc_c;
   logic [0:0]  uc_ovf;

   add_pipe #(.WIDTH(32), .LANES(1), .STAGES(1), .SATURATE(0)) ua (
      .clk(clk), .rst(ua_rst), .in_valid(ua_in_valid), .in_ready(ua_in_ready),
      .mode(ua_mode), .a(ua_a), .b(ua_b), .out_valid(ua_out_valid),
      .out_ready(ua_out_ready), .c(ua_c), .ovf(ua_ovf)
   );

   add_pipe #(.WIDTH(8), .LANES(2), .STAGES(1), .SATURATE(1)) ub (
      .clk(clk), .rst(ub_rst), .in_valid(ub_in_valid), .in_ready(ub_in_ready),
      .mode(ub_mode), .a(ub_a), .b(ub_b), .out_valid(ub_out_valid),
      .out_ready(ub_out_ready), .c(ub_c), .ovf(ub_ovf)
   );

   add_pipe #(.WIDTH(32), .LANES(1), .STAGES(3), .SATURATE(0)) uc (
      .clk(clk), .rst(uc_rst), .in_valid(uc_in_valid), .in_ready(uc_in_ready),
      .mode(uc_mode), .a(uc_a), .b(uc_b), .out_valid(uc_out_valid),
      .out_ready(uc_out_ready), .c(uc_c), .ovf(uc_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic uc_drive(input logic v, input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
      uc_in_valid = v;
      uc_mode     = m;
      uc_a        = x;
      uc_b        = y;
   endtask

   // Watchdog: the run must always end on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p;
      int q;

      ua_rst = 1'b1; ua_in_valid = 1'b0; ua_out_ready = 1'b1; ua_mode = 2'b00; ua_a = '0; ua_b = '0;
      ub_rst = 1'b1; ub_in_valid = 1'b0; ub_out_ready = 1'b1; ub_mode = 2'b00; ub_a = '0; ub_b = '0;
      uc_rst = 1'b1; uc_in_valid = 1'b0; uc_out_ready = 1'b1; uc_mode = 2'b00; uc_a = '0; uc_b = '0;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      #1;
      check("rst_ua_out_valid", ua_out_valid, 0);
      check("rst_ua_c",         ua_c,         0);
      check("rst_ua_in_ready",  ua_in_ready,  1);
      check("rst_uc_out_valid", uc_out_valid, 0);
      check("rst_uc_c",         uc_c,         0);
      check("rst_uc_ovf",       uc_ovf,       0);
      check("rst_uc_in_ready",  uc_in_ready,  1);
      ua_rst = 1'b0; ub_rst = 1'b0; uc_rst = 1'b0;

      // ---------------- ua: wrap, one-cycle latency ----------------
      @(negedge clk);
      ua_in_valid = 1'b1; ua_mode = 2'b00; ua_a = 32'd3; ua_b = 32'd4;
      @(negedge clk); #1;
      check("ua_add_valid", ua_out_valid, 1);
      check("ua_add_c",     ua_c,         32'd7);
      check("ua_add_ovf",   ua_ovf,       0);
      ua_a = 32'h7FFF_FFFF; ua_b = 32'd1;
      @(negedge clk); #1;
      check("ua_wrap_c",   ua_c,   32'h8000_0000);
      check("ua_wrap_ovf", ua_ovf, 1);
      ua_a = 32'h8000_0000; ua_b = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      check("ua_negwrap_c",   ua_c,   32'h7FFF_FFFF);
      check("ua_negwrap_ovf", ua_ovf, 1);
      ua_in_valid = 1'b0;
      @(negedge clk); #1;
      check("ua_idle_valid", ua_out_valid, 0);

      // ---------------- ub: saturate, two lanes ----------------
      @(negedge clk);
      ub_in_valid = 1'b1; ub_mode = 2'b00;
      ub_a = {8'h9C, 8'h64}; ub_b = {8'h9C, 8'h64};     // lane1 -100+-100, lane0 100+100
      @(negedge clk); #1;
      check("ub_sat_c",   ub_c,   16'h807F);
      check("ub_sat_ovf", ub_ovf, 2'b11);
      ub_a = {8'h80, 8'h7F}; ub_b = {8'hFF, 8'h01};     // -128+-1, 127+1
      @(negedge clk); #1;
      check("ub_edge_c",   ub_c,   16'h807F);
      check("ub_edge_ovf", ub_ovf, 2'b11);
      ub_a = {8'h80, 8'h7F}; ub_b = {8'h01, 8'hFF};     // -128+1, 127+-1
      @(negedge clk); #1;
      check("ub_noovf_c",   ub_c,   16'h817E);
      check("ub_noovf_ovf", ub_ovf, 2'b00);
      ub_in_valid = 1'b0;

      // ---------------- uc: accumulate chain, 3-cycle latency ----------------
      @(negedge clk); uc_drive(1'b1, 2'b10, 32'd10, 32'hDEAD);
      @(negedge clk); uc_drive(1'b1, 2'b01, 32'd5, 32'hDEAD);
      @(negedge clk); uc_drive(1'b1, 2'b01, 32'hFFFF_FFEC, 32'hDEAD);   // -20
      #1;
      check("uc_latency_not_yet", uc_out_valid, 0);
      @(negedge clk); uc_drive(1'b1, 2'b01, 32'd1, 32'hDEAD);
      #1;
      check("uc_acc0_valid", uc_out_valid, 1);
      check("uc_acc0_c",     uc_c,         32'd10);
      @(negedge clk); uc_drive(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      check("uc_acc1_c", uc_c, 32'd15);
      @(negedge clk); #1;
      check("uc_acc2_c", uc_c, 32'hFFFF_FFFB);
      @(negedge clk); #1;
      check("uc_acc3_c",     uc_c,         32'hFFFF_FFFC);
      check("uc_acc3_valid", uc_out_valid, 1);
      @(negedge clk); #1;
      check("uc_acc_drained", uc_out_valid, 0);

      // ---------------- uc: backpressure ----------------
      uc_out_ready = 1'b0;
      p = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         uc_drive(p < 5, 2'b00, 32'(100 + p), 32'(p));
         #1;
         if (cyc >= 4) check("bp_hold_c", uc_c, 32'd100);
         if (uc_in_valid && uc_in_ready) p++;
      end
      check("bp_accepted",  32'(p),       32'd3);
      check("bp_in_ready",  uc_in_ready,  0);
      check("bp_out_valid", uc_out_valid, 1);

      q = 0;
      for (int cyc = 0; cyc < 20 && q < 5; cyc++) begin
         @(negedge clk);
         uc_out_ready = 1'b1;
         uc_drive(p < 5, 2'b00, 32'(100 + p), 32'(p));
         #1;
         if (cyc == 0) check("bp_full_in_ready", uc_in_ready, 1);
         if (uc_out_valid) begin
            check("bp_order", uc_c, 32'(100 + 2 * q));
            q++;
         end
         if (uc_in_valid && uc_in_ready) p++;
      end
      uc_in_valid = 1'b0;
      check("bp_emerged",     32'(q), 32'd5);
      check("bp_all_accepted", 32'(p), 32'd5);

      // ---------------- uc: mid-stream reset ----------------
      @(negedge clk); uc_drive(1'b1, 2'b10, 32'd50, 32'd0);
      @(negedge clk); uc_drive(1'b1, 2'b01, 32'd3, 32'd0);
      @(negedge clk); uc_drive(1'b1, 2'b01, 32'd4, 32'd0);
      @(negedge clk); uc_drive(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      check("rs_pre_valid", uc_out_valid, 1);
      check("rs_pre_c",     uc_c,         32'd50);
      #1 uc_rst = 1'b1;
      #1;
      check("rs_async_valid",    uc_out_valid, 0);
      check("rs_async_c",        uc_c,         0);
      check("rs_async_in_ready", uc_in_ready,  1);
      @(negedge clk); uc_rst = 1'b0;
      @(negedge clk); uc_drive(1'b1, 2'b01, 32'd1, 32'd0);
      @(negedge clk); uc_drive(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      check("rs_lost_1", uc_out_valid, 0);
      @(negedge clk); #1;
      check("rs_lost_2", uc_out_valid, 0);
      @(negedge clk); #1;
      check("rs_acc_valid", uc_out_valid, 1);
      check("rs_acc_c",     uc_c,         32'd1);

      // ---------------- uc: reserved mode 11 ----------------
      @(negedge clk); uc_drive(1'b1, 2'b10, 32'd9, 32'd0);
      @(negedge clk); uc_drive(1'b1, 2'b11, 32'd2, 32'd3);
      @(negedge clk); uc_drive(1'b1, 2'b01, 32'd1, 32'd0);
      @(negedge clk); uc_drive(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      check("m11_load_c", uc_c, 32'd9);
      @(negedge clk); #1;
      check("m11_add_c",   uc_c,   32'd5);
      check("m11_add_ovf", uc_ovf, 0);
      @(negedge clk); #1;
      check("m11_acc_c", uc_c, 32'd10);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined, multi-lane integer adder with valid/ready handshake, per-lane running accumulators, and selectable wrap or saturate overflow handling. It is the clocked successor to the plain continuous-assign adder. It sits between a producer and consumer stream in elaborated test designs and exercises multi-stage `prb`/`drv` lowering with backpressure.

## Interface
- `WIDTH`, 32: bits per lane operand and result (>= 2).
- `LANES`, 1: independent parallel lanes sharing one handshake (>= 1).
- `STAGES`, 1: pipeline latency in cycles (>= 1).
- `SATURATE`, 0: 0 = two's-complement wrap, 1 = clamp to signed min/max.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts beat this cycle.
- `mode` in 2: 00 ADD, 01 ACC, 10 LOAD, 11 treated as ADD.
- `a` in LANES*WIDTH: lane i operand at bits [i*WIDTH +: WIDTH], signed.
- `b` in LANES*WIDTH: second operand, same packing, signed.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: consumer accepts result.
- `c` out LANES*WIDTH: lane results, same packing.
- `ovf` out LANES: per-lane signed-overflow flag travelling with `c`.

## Operation
- Acceptance: a beat is accepted on a rising edge where `in_valid && in_ready`. `mode`, `a` and `b` are sampled only then.
- Per-lane result r at acceptance:
  - ADD: r = a + b.
  - ACC: r = acc + a, with `b` ignored.
  - LOAD: r = a, with ovf = 0.
- Overflow: the sum is computed at WIDTH+1 bits. Signed overflow occurs when both operands have the same sign and the WIDTH-bit result sign differs. `ovf[i]` is set to 1 on overflow.
  - SATURATE=0: the result is the low WIDTH bits.
  - SATURATE=1: a positive overflow gives 2^(WIDTH-1)-1; a negative overflow gives -2^(WIDTH-1).
- Accumulators: there is one WIDTH-bit register acc per lane.
  - On acceptance in ACC or LOAD mode, acc <= r, the final wrapped or saturated value.
  - ADD does not modify acc.
  - Back-to-back ACC beats chain with no bubble: each beat sees the acc written by the previous accepted beat.
- Pipeline: r and ovf enter stage 1 on acceptance. Stages 2..STAGES are pure delay registers, each with its own valid bit. The output equals the final stage.
- Flow control: stage k is "free" if it is invalid or advancing. Stage k advances when stage k+1 is free; the last stage advances when `out_ready`. `in_ready` = stage 1 is free. The ready chain is combinational, so a bubble anywhere is collapsed.
- `out_valid`, `c` and `ovf` are held stable while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous): all stage valids 0, all stage data and ovf 0, all acc 0. Outputs during and after reset: `out_valid`=0, `c`=0, `ovf`=0, `in_ready`=1.
- Reset asserted mid-operation discards all in-flight beats and accumulator state immediately. No beat completes across reset.
- Latency: a beat accepted at edge t appears with `out_valid`=1 after edge t+STAGES-1 completes, i.e. visible in the cycle following edge t+STAGES-1, when there is no stall. For STAGES=1 the result is visible the cycle after acceptance.
- Throughput: one beat per cycle when `out_ready` is held high.
- Full pipeline with `out_ready`=0: all STAGES valid, `in_ready`=0, and nothing changes, including acc.
- Simultaneous events:
  - When full and `out_ready`=1, an output handshake and an input acceptance occur on the same edge, and the pipeline stays full.
  - `in_valid` with `in_ready`=0 has no effect on acc.
- Reserved mode 11 behaves exactly as ADD, including leaving acc untouched.

## Test plan
- WIDTH=32, LANES=1, STAGES=1, SATURATE=0. Sequence: ADD 3+4, then ADD 0x7FFFFFFF+1. Required: c=7 ovf=0; then c=0x80000000 ovf=1; each one cycle after acceptance.
- SATURATE=1, WIDTH=8, LANES=2. Lane0: 100+100. Lane1: -100+-100. Required: c lane0=127, lane1=-128, ovf=2'b11.
- STAGES=3. Sequence: LOAD a=10, then ACC a=5, ACC a=-20, ACC a=1, back-to-back with `out_ready`=1. Required: outputs 10, 15, -5, -4 on consecutive cycles, first one 3 cycles after the first acceptance.
- STAGES=3 with `out_ready`=0 and 5 beats offered. Required: exactly 3 accepted, `in_ready`=0 thereafter, `c` stable. Then release `out_ready`. Required: beats emerge in order and the remaining 2 are accepted.
- Mid-stream reset. Sequence: LOAD 50, then assert `rst` while 2 beats are in flight, release, then ACC a=1. Required: `out_valid` drops asynchronously, in-flight beats are lost, and the output is 1 (acc reset to 0).
- Mode 11 with a=2, b=3 after LOAD 9, followed by ACC a=1. Required: outputs 5, then 10.
